lemon_ifu: RTL
==============

// Module: lemon_ifu
// PURPOSE
//   Instruction fetch unit for LemonPC; the stage directly upstream of the control decoder.
//   Owns the architectural PC and fetches 32-bit instructions over a req/ack instruction-memory port.
//   Presents each instruction with a valid/ready handshake; the decoder's `inst` input is driven from `inst`.
//   Applies the next PC (sequential or redirect) and honours halt (ebreak).
// PARAMETERS
//   XLEN      64            PC / address width
//   RESET_PC  64'h8000_0000 PC after reset; must be 4-byte aligned
// PORTS
//   clk             in   1     clock; all state updates on posedge
//   rst_n           in   1     reset, asynchronous, active-low
//   imem_req        out  1     fetch request to instruction memory
//   imem_addr       out  XLEN  fetch address (== pc)
//   imem_ack        in   1     memory response; sampled at posedge while imem_req=1
//   imem_rdata      in   32    instruction word, valid in the imem_ack cycle
//   imem_err        in   1     access fault, qualified by imem_ack
//   inst_valid      out  1     inst/pc hold a fetched instruction
//   inst            out  32    instruction word to decoder
//   pc              out  XLEN  address of inst
//   inst_ready      in   1     downstream consumes inst this cycle
//   redirect_valid  in   1     taken jump/branch (pc_sel = alu), qualified by handshake
//   redirect_pc     in   XLEN  jump target
//   halt            in   1     ebreak retired, qualified by handshake
//   halted          out  1     fetch stopped (halt or fault)
//   fetch_err       out  1     sticky: access fault or misaligned target
//   inst_cnt        out  64    count of consumed instructions
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE; pc=imem_addr=RESET_PC; imem_req=0; inst_valid=0;
//     inst=32'h0000_0013 (NOP); halted=0; fetch_err=0; inst_cnt=0.
//     Any outstanding request is abandoned; the memory tolerates a dropped request.
//   States: IDLE -> REQ -> VALID -> REQ ... ; HALT is terminal until reset.
//     IDLE : first posedge after rst_n release -> REQ.
//     REQ  : imem_req=1, imem_addr=pc, both held stable until ack.
//            ack & !err -> latch inst=imem_rdata, inst_valid=1, go VALID.
//            ack & err  -> fetch_err=1, halted=1, go HALT (inst_valid stays 0).
//     VALID: inst/pc held stable while inst_ready=0.
//            Handshake fire = inst_valid & inst_ready: inst_cnt+=1, inst_valid=0, then:
//              halt=1                           -> go HALT, halted=1 (halt wins over redirect).
//              redirect_valid & redirect_pc[1:0]!=0 -> fetch_err=1, halted=1, go HALT.
//              redirect_valid                   -> pc=redirect_pc, go REQ.
//              else                             -> pc=pc+4 (mod 2^XLEN, wraps silently), go REQ.
//     HALT : imem_req=0, inst_valid=0; all inputs ignored.
//   redirect_valid/halt are ignored outside the fire cycle; no speculation, one instruction in flight.
//   Latency: ack in the first REQ cycle -> inst_valid in the next cycle; minimum 2 cycles/instruction.
//   imem_ack while imem_req=0 is ignored. inst_cnt wraps at 2^64.
// STRUCTURE
//   defines.v (shared): LEMON_RESET_PC, LEMON_NOP (32'h13), ifu state encodings (2-bit).
//   One sub-module, ifu_pc_next: combinational next-PC mux (pc+4 / redirect_pc) with alignment check.
//   Remaining logic (FSM, pc/inst registers, counter) stays in lemon_ifu.
// TESTING
//   Reset release, zero-wait memory, inst_ready=1: addrs 8000_0000, _0004, _0008; inst_valid every 2nd cycle.
//   Ack delayed 3 cycles: imem_req/imem_addr stable throughout; inst_valid rises the cycle after ack.
//   inst_ready low 4 cycles in VALID: inst/pc unchanged; no new imem_req; inst_cnt unchanged.
//   Fire with redirect_valid, target 8000_0100 -> next imem_addr=8000_0100; target 8000_0102 -> fetch_err=1, halted=1.
//   Fire with halt=1 and redirect_valid=1 -> halted=1, imem_req stays 0 forever, inst_cnt frozen.
//   rst_n low mid-REQ (ack pending) -> outputs at reset values immediately; refetch at RESET_PC. imem_err on ack -> halt.

Source files
------------

// File: rtl/lemon_ifu_pkg.sv
// lemon_ifu_pkg: shared reset PC, NOP encoding and fetch FSM state encoding for the LemonPC IFU
package lemon_ifu_pkg;
  localparam logic [63:0] LEMON_RESET_PC = 64'h8000_0000;
  localparam logic [31:0] LEMON_NOP = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, VALID = 2'd2, HALT = 2'd3} ifu_state_e;
endpackage

// File: rtl/lemon_ifu_pc_next.sv
// lemon_ifu_pc_next: next-PC mux (pc+4 or redirect target) with target alignment check
module lemon_ifu_pc_next #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);
  assign next_pc = redirect_valid ? redirect_pc : pc + XLEN'(4);
  assign misaligned = redirect_valid & |redirect_pc[1:0];
endmodule

// File: rtl/lemon_ifu.sv
// lemon_ifu: instruction fetch unit owning the PC, one fetch in flight, valid/ready to the decoder
module lemon_ifu
  import lemon_ifu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(LEMON_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_err,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  input  logic            inst_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            halted,
  output logic            fetch_err,
  output logic [63:0]     inst_cnt
);
  ifu_state_e state, state_n;
  logic [XLEN-1:0] next_pc;
  logic misaligned, fire, load, take, fault;
  lemon_ifu_pc_next #(.XLEN(XLEN)) u_pc_next (
    .pc(pc),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .next_pc(next_pc),
    .misaligned(misaligned)
  );
  always_comb begin
    state_n = state;
    imem_req = state == REQ;
    inst_valid = state == VALID;
    halted = state == HALT;
    fire = inst_valid & inst_ready;
    load = imem_req & imem_ack & ~imem_err;
    take = fire & ~halt & ~misaligned;
    fault = (imem_req & imem_ack & imem_err) | (fire & ~halt & misaligned);
    state_n = state == IDLE  ? REQ :
              state == REQ   ? (imem_ack ? (imem_err ? HALT : VALID) : REQ) :
              state == VALID ? (fire ? ((halt | misaligned) ? HALT : REQ) : VALID) :
                               HALT;
  end
  assign imem_addr = pc;
  // async reset abandons any outstanding request; the memory tolerates the drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      inst <= LEMON_NOP;
      fetch_err <= 1'b0;
      inst_cnt <= '0;
    end else begin
      state <= state_n;
      if (take) pc <= next_pc;
      if (load) inst <= imem_rdata;
      fetch_err <= fetch_err | fault;
      inst_cnt <= inst_cnt + {63'd0, fire};
    end
  end
endmodule
